// File: rtl/spread_sched_pkg.sv
// Shared types and widths for the spread-calculation scheduler.
// Holds the FSM state enum, position/maturity/tier/charge typedefs, the
// configuration bundle struct and a helper that sizes requester indices.
package spread_sched_pkg;

  localparam int POS_W  = 16;
  localparam int MAT_W  = 8;
  localparam int TIER_W = 4;
  localparam int NLEG   = 8;   // legs per portfolio
  localparam int NTIER  = 3;
  localparam int NCHG   = 6;
  localparam int NOUT   = 3;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic        [MAT_W-1:0] mat_t;
  typedef logic       [TIER_W-1:0] tier_t;
  typedef logic              [7:0] charge_t;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RESP} state_e;

  typedef struct packed {
    tier_t   [NTIER-1:0] tier_max;
    charge_t [NCHG-1:0]  charge;
    charge_t [NOUT-1:0]  outright;
  } cfg_t;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Ports: clk, reset (sync, active high); req[NREQ] requests; en allows a
// grant this cycle; grant[NREQ] one-hot grant; grant_idx encoded grant.
// Any grant issued is an acceptance (grants only go to asserted requests),
// so the priority pointer moves to the slot after the winner.
module rr_arbiter
  import spread_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] ptr;
  logic           found;
  int             idx;

  // Scan from the pointer, wrapping once; first asserted request wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
    grant = (en && found) ? (NREQ'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (|grant)
      ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
  end

endmodule

// File: rtl/spread_calc_scheduler.sv
// Spread-calculation scheduler: serialises portfolio jobs from NREQ
// requesters onto a single inter-month spread engine.
// Per job: accept (IDLE) -> LOAD (engine cleared one cycle) -> SETTLE
// (SETTLE_CYCLES cycles, TSC captured on the last) -> RESP (held until
// rsp_ready). Configuration writes are taken only in IDLE and beat any
// simultaneous request.
// Ports: clk, reset (sync, active high); req_valid/req_ready/req_pos/req_mat
// job request side; cfg_wr/cfg_ready/cfg_* configuration; eng_* engine
// drive, eng_reset_n engine reset, eng_tsc engine result; rsp_valid/
// rsp_ready/rsp_id/rsp_tsc result handshake.
// Optional: define SPREAD_SCHED_STATS_EN to add stat_jobs (completed
// responses) and stat_busy (non-IDLE cycles), both saturating.
module spread_calc_scheduler
  import spread_sched_pkg::*;
#(
  parameter  int NREQ          = 4,
  parameter  int SETTLE_CYCLES = 12,
  localparam int IDW           = id_width(NREQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  pos_t [NREQ-1:0][NLEG-1:0]  req_pos,
  input  mat_t [NREQ-1:0][NLEG-1:0]  req_mat,
  input  logic                       cfg_wr,
  output logic                       cfg_ready,
  input  tier_t   [NTIER-1:0]        cfg_tier_max,
  input  charge_t [NCHG-1:0]         cfg_charge,
  input  charge_t [NOUT-1:0]         cfg_outright,
  output pos_t    [NLEG-1:0]         eng_pos,
  output mat_t    [NLEG-1:0]         eng_mat,
  output tier_t   [NTIER-1:0]        eng_tier_max,
  output charge_t [NCHG-1:0]         eng_charge,
  output charge_t [NOUT-1:0]         eng_outright,
  output logic                       eng_reset_n,
  input  logic [15:0]                eng_tsc,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [15:0]                rsp_tsc
`ifdef SPREAD_SCHED_STATS_EN
  ,
  output logic [15:0]                stat_jobs,
  output logic [31:0]                stat_busy
`endif
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("spread_calc_scheduler: SETTLE_CYCLES must be >= 1");
  end

  state_e          state, state_nx;
  logic [CW-1:0]   settle_cnt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            arb_en;
  logic            eng_clr;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready   = grant;
  assign eng_reset_n = ~(reset | eng_clr);

  always_comb begin
    state_nx  = state;
    arb_en    = 1'b0;
    cfg_ready = 1'b0;
    eng_clr   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_wr) begin
          cfg_ready = 1'b1;
        end else begin
          arb_en = 1'b1;
          if (|grant) state_nx = LOAD;
        end
      end
      LOAD: begin
        eng_clr  = 1'b1;
        state_nx = SETTLE;
      end
      SETTLE: if (settle_cnt == CW'(1)) state_nx = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Handshakes are combinational from state; keep them quiet while reset
    // is applied, before the state register has been forced to IDLE.
    if (reset) begin
      arb_en    = 1'b0;
      cfg_ready = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      eng_pos      <= '0;
      eng_mat      <= '0;
      eng_tier_max <= '0;
      eng_charge   <= '0;
      eng_outright <= '0;
      rsp_id       <= '0;
      rsp_tsc      <= '0;
    end else begin
      state <= state_nx;
      // Down-counter: loaded in LOAD, last SETTLE cycle is when it reads 1.
      if (state == LOAD)
        settle_cnt <= CW'(SETTLE_CYCLES);
      else if (state == SETTLE)
        settle_cnt <= settle_cnt - CW'(1);
      if (state == SETTLE && settle_cnt == CW'(1))
        rsp_tsc <= eng_tsc;
      if (cfg_ready) begin
        eng_tier_max <= cfg_tier_max;
        eng_charge   <= cfg_charge;
        eng_outright <= cfg_outright;
      end
      if (|grant) begin
        eng_pos <= req_pos[grant_idx];
        eng_mat <= req_mat[grant_idx];
        rsp_id  <= grant_idx;
      end
    end
  end

`ifdef SPREAD_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_jobs <= '0;
      stat_busy <= '0;
    end else begin
      if (rsp_valid && rsp_ready && stat_jobs != '1) stat_jobs <= stat_jobs + 16'd1;
      if (state != IDLE && stat_busy != '1)         stat_busy <= stat_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spread_calc_scheduler.sv
// Directed bench for spread_calc_scheduler. A stand-in engine produces a
// TSC that equals the expected spread charge only on the cycle the
// scheduler is meant to sample it, so early/late capture shows up.
// Stats checks are compiled only with SPREAD_SCHED_STATS_EN.
module tb_spread_calc_scheduler;
  import spread_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int S    = 12;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  pos_t [NREQ-1:0][NLEG-1:0] req_pos;
  mat_t [NREQ-1:0][NLEG-1:0] req_mat;
  logic                      cfg_wr;
  logic                      cfg_ready;
  tier_t   [NTIER-1:0]       cfg_tier_max;
  charge_t [NCHG-1:0]        cfg_charge;
  charge_t [NOUT-1:0]        cfg_outright;
  pos_t    [NLEG-1:0]        eng_pos;
  mat_t    [NLEG-1:0]        eng_mat;
  tier_t   [NTIER-1:0]       eng_tier_max;
  charge_t [NCHG-1:0]        eng_charge;
  charge_t [NOUT-1:0]        eng_outright;
  logic                      eng_reset_n;
  logic [15:0]               eng_tsc;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [1:0]                rsp_id;
  logic [15:0]               rsp_tsc;
`ifdef SPREAD_SCHED_STATS_EN
  logic [15:0]               stat_jobs;
  logic [31:0]               stat_busy;
`endif

  always #5 clk = ~clk;

  spread_calc_scheduler #(.NREQ(NREQ), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pos(req_pos), .req_mat(req_mat),
    .cfg_wr(cfg_wr), .cfg_ready(cfg_ready),
    .cfg_tier_max(cfg_tier_max), .cfg_charge(cfg_charge), .cfg_outright(cfg_outright),
    .eng_pos(eng_pos), .eng_mat(eng_mat), .eng_tier_max(eng_tier_max),
    .eng_charge(eng_charge), .eng_outright(eng_outright),
    .eng_reset_n(eng_reset_n), .eng_tsc(eng_tsc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tsc(rsp_tsc)
`ifdef SPREAD_SCHED_STATS_EN
    , .stat_jobs(stat_jobs), .stat_busy(stat_busy)
`endif
  );

  // Stand-in engine: cycles since engine reset release.
  logic [15:0] ecnt;
  always @(posedge clk) begin
    if (!eng_reset_n) ecnt <= 16'd0;
    else              ecnt <= ecnt + 16'd1;
  end

  // Two-leg calendar spread: opposite-sign legs pair off min(|a|,|b|) lots.
  function automatic logic [15:0] spread(input pos_t a, input pos_t b, input charge_t c);
    int x, y, m;
    x = (a < 0) ? -int'(a) : int'(a);
    y = (b < 0) ? -int'(b) : int'(b);
    m = 0;
    if ((a < 0) != (b < 0) && x != 0 && y != 0) m = (x < y) ? x : y;
    return 16'(m * int'(c));
  endfunction

  assign eng_tsc = spread(eng_pos[0], eng_pos[1], eng_charge[0]) + ecnt - 16'(S - 1);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input charge_t c0);
    cfg_tier_max = {4'd12, 4'd8, 4'd4};
    cfg_charge   = '0;
    cfg_charge[0] = c0;
    cfg_outright = '0;
    cfg_wr = 1'b1;
    #1;
    chk("cfg_ready", 32'(cfg_ready), 32'd1);
    tick;
    cfg_wr = 1'b0;
    chk("cfg_charge0", 32'(eng_charge[0]), 32'(c0));
    chk("cfg_tier2", 32'(eng_tier_max[2]), 32'd12);
  endtask

  // Entered in IDLE with requests set; returns in IDLE after the handshake,
  // or still in RESP when hold=1.
  task automatic run_job(input int id, input logic [15:0] tsc, input bit hold);
    int lat;
    #1;
    chk("grant", 32'(req_ready), 32'(1) << id);
    lat = 0;
    do begin
      tick;
      lat++;
      if (lat == 1) begin
        chk("load_rst_n", 32'(eng_reset_n), 32'd0);
        chk("busy_ready", 32'(req_ready), 32'd0);
      end
      if (lat == 2) chk("settle_rst_n", 32'(eng_reset_n), 32'd1);
    end while (!rsp_valid && lat < 40);
    chk("rsp_lat", 32'(lat), 32'd14);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_tsc", 32'(rsp_tsc), 32'(tsc));
    if (!hold) tick;
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    req_valid = 4'hF;
    cfg_wr = 1'b1;
    cfg_tier_max = '0;
    cfg_charge = '0;
    cfg_charge[0] = 8'd9;
    cfg_outright = '0;
    req_pos = '0;
    req_mat = '0;
    rsp_ready = 1'b1;
    repeat (2) tick;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_tsc", 32'(rsp_tsc), 32'd0);
    chk("rst_eng_rst_n", 32'(eng_reset_n), 32'd0);
    chk("rst_eng_charge", 32'(eng_charge[0]), 32'd0);
    chk("rst_eng_pos", 32'(eng_pos[0]), 32'd0);

    reset = 1'b0;
    req_valid = '0;
    cfg_wr = 1'b0;
    req_pos[0][0] = 16'sd10; req_mat[0][0] = 8'd1;
    req_pos[0][1] = -16'sd4; req_mat[0][1] = 8'd2;
    req_pos[1][0] = 16'sd3;  req_pos[1][1] = -16'sd7;
    req_pos[2][0] = -16'sd6; req_pos[2][1] = 16'sd2;
    req_pos[3][0] = 16'sd1;  req_pos[3][1] = 16'sd1;
    tick;

    // Single job from requester 0: spread 4 lots x 5 = 20.
    do_cfg(8'd5);
    req_valid = 4'b0001;
    run_job(0, 16'd20, 1'b0);
    chk("eng_pos0", 32'(eng_pos[0]), 32'd10);
    chk("eng_pos1", 32'(eng_pos[1]), 32'hFFFF_FFFC);
    chk("eng_mat1", 32'(eng_mat[1]), 32'd2);

    // Reset returns pointer to 0; all four requesting -> 0,1,2,3,0.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    do_cfg(8'd5);
    req_valid = 4'hF;
    run_job(0, 16'd20, 1'b0);
    run_job(1, 16'd15, 1'b0);
    run_job(2, 16'd10, 1'b0);
    run_job(3, 16'd0,  1'b0);
    run_job(0, 16'd20, 1'b0);

    // Back-pressure: response must hold, no new grants, cfg ignored.
    rsp_ready = 1'b0;
    run_job(1, 16'd15, 1'b1);
    cfg_wr = 1'b1;
    cfg_charge[0] = 8'd99;
    bad = 0;
    repeat (20) begin
      tick;
      if (!rsp_valid || rsp_id != 2'd1 || rsp_tsc != 16'd15 || req_ready != 4'd0 || cfg_ready)
        bad++;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    chk("stall_cfg_ignored", 32'(eng_charge[0]), 32'd5);
    cfg_wr = 1'b0;
    rsp_ready = 1'b1;
    tick;

    // Config and request in the same IDLE cycle: config first.
    req_valid = 4'b0100;
    cfg_charge[0] = 8'd7;
    cfg_wr = 1'b1;
    #1;
    chk("cfg_win_ready", 32'(cfg_ready), 32'd1);
    chk("cfg_win_req", 32'(req_ready), 32'd0);
    tick;
    cfg_wr = 1'b0;
    run_job(2, 16'd14, 1'b0);

    // Reset in SETTLE cycle 5 drops the job for requester 3.
    req_valid = 4'b1000;
    #1;
    chk("pre_rst_grant", 32'(req_ready), 32'd8);
    tick;
    req_valid = '0;
    repeat (5) tick;
    reset = 1'b1;
    #1;
    chk("mid_rst_rst_n", 32'(eng_reset_n), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    tick;
    reset = 1'b0;
    #1;
    chk("post_rst_charge", 32'(eng_charge[0]), 32'd0);
    bad = 0;
    repeat (20) begin
      tick;
      if (rsp_valid) bad++;
    end
    chk("dropped_no_rsp", 32'(bad), 32'd0);
    do_cfg(8'd5);
    req_valid = 4'b1010;
    run_job(1, 16'd15, 1'b0);
    req_valid = '0;

`ifdef SPREAD_SCHED_STATS_EN
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("stat_rst_jobs", 32'(stat_jobs), 32'd0);
    do_cfg(8'd5);
    req_valid = 4'hF;
    run_job(0, 16'd20, 1'b0);
    run_job(1, 16'd15, 1'b0);
    run_job(2, 16'd10, 1'b0);
    req_valid = '0;
    chk("stat_jobs", 32'(stat_jobs), 32'd3);
    chk("stat_busy", stat_busy, 32'd42);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spread_calc_scheduler.md
SPREAD_CALC_SCHEDULER -- requirements
Module: spread_calc_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of portfolio requesters.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 12, giving the engine cycles waited after clear before capturing TSC.
REQ-003 Port clk, input, 1: the single clock; all logic on posedge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port req_valid, input, NREQ: per-requester job request.
REQ-006 Port req_ready, output, NREQ: per-requester grant; a job is accepted when req_valid[i]&req_ready[i].
REQ-007 Port req_pos, input, NREQ x 8 x 16: signed positions per requester.
REQ-008 Port req_mat, input, NREQ x 8 x 8: maturities per requester.
REQ-009 Port cfg_wr, input, 1: configuration write strobe.
REQ-010 Port cfg_ready, output, 1: configuration accepted this cycle.
REQ-011 Port cfg_tier_max, cfg_charge, cfg_outright, inputs, 3x4 / 6x8 / 3x8: new tier and charge set.
REQ-012 Ports eng_pos, eng_mat, eng_tier_max, eng_charge, eng_outright, outputs, widths matching REQ-007/008/011: drive the inter-month spread engine.
REQ-013 Port eng_reset_n, output, 1: engine active-low reset, equal to ~(reset | eng_clr).
REQ-014 Port eng_tsc, input, 16: engine total spread charge.
REQ-015 Ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_id (out, clog2(NREQ)), rsp_tsc (out, 16): result handshake.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, SETTLE, RESP.
REQ-017 In IDLE with cfg_wr=1, the block SHALL assert cfg_ready, latch the cfg_* inputs into eng_* configuration registers, and hold req_ready=0 that cycle, so cfg wins over simultaneous requests.
REQ-018 cfg_ready SHALL be 0 outside IDLE; cfg_wr outside IDLE SHALL be ignored.
REQ-019 In IDLE with cfg_wr=0, at most one req_ready bit SHALL be high, chosen round-robin from the priority pointer among asserted req_valid bits.
REQ-020 On acceptance of requester i (cycle T), the block SHALL latch req_pos[i], req_mat[i] and id i, set pointer=(i+1) mod NREQ, and enter LOAD.
REQ-021 LOAD (cycle T+1) SHALL assert eng_clr for exactly one cycle; eng_pos/eng_mat SHALL show the latched job from T+1 until the next acceptance.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles (T+2 .. T+1+SETTLE_CYCLES); on its last cycle the block SHALL register eng_tsc into rsp_tsc.
REQ-023 RESP SHALL assert rsp_valid from T+2+SETTLE_CYCLES; rsp_id and rsp_tsc SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-024 On rsp_valid&rsp_ready the block SHALL return to IDLE next cycle; the earliest next acceptance is one cycle later.
REQ-025 Requests held during a busy job SHALL remain pending without loss; req_ready SHALL be 0 outside IDLE.
REQ-026 The SETTLE counter SHALL be ceil(log2(SETTLE_CYCLES+1)) bits; SETTLE_CYCLES<1 SHALL be a elaboration error.

Reset
REQ-027 While reset=1: state=IDLE, pointer=0, req_ready=0, cfg_ready=0, rsp_valid=0, rsp_id=0, rsp_tsc=0, eng_* data and config=0, eng_reset_n=0.
REQ-028 Reset mid-job SHALL drop the job without emitting a response.

Configuration
REQ-029 With SPREAD_SCHED_STATS_EN defined, outputs stat_jobs (16b) and stat_busy (32b) SHALL exist, counting completed responses and non-IDLE cycles; both saturate at all-ones and clear on reset.
REQ-030 Without SPREAD_SCHED_STATS_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-031 Package spread_sched_pkg SHALL hold the state enum, position/maturity/charge typedefs, and the widths 16/8/4.
REQ-032 Round-robin selection SHALL be sub-module rr_arbiter (NREQ req in, one-hot grant out, pointer update on accept).

Verification
REQ-033 After reset, single req 0 with pos[0]=10/mat 1 and pos[1]=-4/mat 2, cfg tier_max={4,8,12}, charge[0]=5, real engine -> rsp_valid at T+14, rsp_id=0, rsp_tsc=20.
REQ-034 req_valid=4'b1111 held -> grants in order 0,1,2,3,0, with one grant per job.
REQ-035 rsp_ready=0 for 20 cycles -> rsp_valid, rsp_id and rsp_tsc stable, no new req_ready.
REQ-036 cfg_wr=1 and req_valid[2]=1 in the same IDLE cycle -> cfg_ready=1, req_ready=0, grant to 2 next cycle with new config applied.
REQ-037 reset pulse during SETTLE cycle 5 -> no rsp_valid, pointer=0, eng_reset_n=0 during reset, next grant goes to the lowest valid index.
REQ-038 With SPREAD_SCHED_STATS_EN, 3 jobs with SETTLE_CYCLES=12 and immediate rsp_ready -> stat_jobs=3, stat_busy=42.
